rvfi_retire_monitor: RTL
========================

RVFI_RETIRE_MONITOR -- requirements
Module: rvfi_retire_monitor

Interface
REQ-001 Parameter: COUNT_W, 32, width of the retired-instruction counter.
REQ-002 Parameter: TIMEOUT, 1024, maximum idle cycles between retirements in RUN before a timeout error.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high. Ports are clk_i and rst_i.
REQ-004 Port: clk_i  in  1  clock.
REQ-005 Port: rst_i  in  1  asynchronous active-high reset.
REQ-006 Port: rvfi_valid  in  1  one instruction retires this cycle.
REQ-007 Port: rvfi_order  in  64  retirement index.
REQ-008 Port: rvfi_trap  in  1  retiring instruction trapped.
REQ-009 Port: rvfi_halt  in  1  retiring instruction is the last one.
REQ-010 Port: rvfi_rd_addr  in  5  destination register.
REQ-011 Port: rvfi_rd_wdata  in  32  destination write data.
REQ-012 Port: rvfi_pc_rdata  in  32  PC of retiring instruction.
REQ-013 Port: rvfi_pc_wdata  in  32  next PC.
REQ-014 Port: clear_i  in  1  synchronous soft clear, same effect as reset.
REQ-015 Port: retired_count_o  out  COUNT_W  retirements accepted, saturating.
REQ-016 Port: trap_count_o  out  16  retirements with rvfi_trap=1, saturating.
REQ-017 Port: state_o  out  2  IDLE=0, RUN=1, HALTED=2, ERROR=3.
REQ-018 Port: err_o  out  1  sticky error flag.
REQ-019 Port: err_code_o  out  3  code of first error: 0 none, 1 order, 2 pc, 3 x0, 4 post-halt, 5 timeout.
REQ-020 Port: err_order_o  out  64  rvfi_order of the retirement that raised the first error (0 for timeout).

Function
REQ-021 All checks evaluate only on cycles where rvfi_valid=1, except the timeout check.
REQ-022 IDLE: first retirement must have rvfi_order=0; otherwise the order error is raised. On a valid retirement, go to RUN, or to HALTED if rvfi_halt=1.
REQ-023 RUN: rvfi_order must equal previous order+1 (64-bit wrap), else order error.
REQ-024 RUN: rvfi_pc_rdata must equal the stored previous rvfi_pc_wdata, else pc error.
REQ-025 The pc check is skipped when the previous retirement had rvfi_trap=1.
REQ-026 Any state: rvfi_rd_addr=0 with rvfi_rd_wdata!=0 raises the x0 error.
REQ-027 HALTED: any rvfi_valid=1 raises the post-halt error.
REQ-028 RUN: rvfi_halt=1 on a clean retirement transitions to HALTED after that retirement is counted.
REQ-029 RUN: an idle counter increments each cycle with rvfi_valid=0 and clears on rvfi_valid=1.
REQ-030 When the idle counter reaches TIMEOUT-1 and the following cycle is also idle, the timeout error is raised.
REQ-031 The idle counter is inactive in IDLE, HALTED and ERROR.
REQ-032 If several errors occur in one cycle, err_code_o takes the lowest nonzero code.
REQ-033 Any error moves the block to ERROR on the next edge and sets err_o, err_code_o and err_order_o. ERROR is absorbing until reset or clear_i.
REQ-034 In ERROR: counters freeze and later errors do not overwrite err_code_o or err_order_o.
REQ-035 retired_count_o increments on every valid retirement in IDLE/RUN, including the erroring one. It saturates at all-ones.
REQ-036 trap_count_o increments when rvfi_valid and rvfi_trap are both 1 in IDLE/RUN. It saturates at 0xFFFF.
REQ-037 Stored previous order, previous pc_wdata and previous trap update on every valid retirement in IDLE/RUN.
REQ-038 Outputs are registered: each update is visible the cycle after the triggering edge.
REQ-039 clear_i has priority over all checks in the same cycle.

Reset
REQ-040 On rst_i=1, immediately and regardless of clk_i, all outputs, counters and stored state go to 0 and state_o goes to IDLE.
REQ-041 Reset asserted mid-operation discards all history. The first retirement after release is checked as in IDLE.

Verification
REQ-042 Clean run: orders 0,1,2 at PCs 0x0,0x4,0x8 (pc_wdata = PC+4); halt on order 2 -> retired_count_o=3, state_o=HALTED, err_o=0.
REQ-043 Order gap: orders 0,1,3 -> err_code_o=1, err_order_o=3, state_o=ERROR, retired_count_o=3.
REQ-044 PC break: order 1 has pc_rdata=0x10 while previous pc_wdata=0x4 -> err_code_o=2. Same case with previous trap=1 -> no error, trap_count_o=1.
REQ-045 Simultaneous errors: order gap plus rd_addr=0 with rd_wdata=5 -> err_code_o=1. A later pc error leaves err_code_o=1.
REQ-046 TIMEOUT=8: one retirement, then 8 idle cycles -> err_code_o=5, err_order_o=0.
REQ-047 Post-halt retirement -> err_code_o=4. Then pulse rst_i between clock edges -> immediately all outputs 0 and state_o=IDLE.

Source files
------------

// File: rtl/rvfi_retire_monitor.sv
// RVFI retirement stream checker: order, pc continuity, x0 writes,
// post-halt activity and retirement timeout, with first-error capture.
module rvfi_retire_monitor #(
   parameter int COUNT_W = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               rvfi_valid,
   input  logic [63:0]        rvfi_order,
   input  logic               rvfi_trap,
   input  logic               rvfi_halt,
   input  logic [4:0]         rvfi_rd_addr,
   input  logic [31:0]        rvfi_rd_wdata,
   input  logic [31:0]        rvfi_pc_rdata,
   input  logic [31:0]        rvfi_pc_wdata,
   input  logic               clear_i,
   output logic [COUNT_W-1:0] retired_count_o,
   output logic [15:0]        trap_count_o,
   output logic [1:0]         state_o,
   output logic               err_o,
   output logic [2:0]         err_code_o,
   output logic [63:0]        err_order_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2,
      ERROR  = 2'd3
   } state_t;

   localparam int IW = $clog2(TIMEOUT) + 1;

   state_t        state;
   logic [63:0]   prev_order;
   logic [31:0]   prev_pc;
   logic          prev_trap;
   logic [IW-1:0] idle_cnt;

   logic       active;
   logic       order_err;
   logic       pc_err;
   logic       x0_err;
   logic       halt_err;
   logic       to_err;
   logic [2:0] code;

   assign active = (state == IDLE) || (state == RUN);

   assign order_err = rvfi_valid &&
      (((state == IDLE) && (rvfi_order != 64'd0)) ||
       ((state == RUN) && (rvfi_order != prev_order + 64'd1)));

   // A trapping instruction legitimately redirects, so its pc_wdata is not trusted
   assign pc_err = rvfi_valid && (state == RUN) && !prev_trap &&
                   (rvfi_pc_rdata != prev_pc);

   assign x0_err = rvfi_valid && (state != ERROR) &&
                   (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0);

   assign halt_err = rvfi_valid && (state == HALTED);

   assign to_err = !rvfi_valid && (state == RUN) &&
                   (idle_cnt == IW'(TIMEOUT - 1));

   // Lowest code wins when several checks fire together
   always_comb begin
      code = 3'd0;
      if (order_err)     code = 3'd1;
      else if (pc_err)   code = 3'd2;
      else if (x0_err)   code = 3'd3;
      else if (halt_err) code = 3'd4;
      else if (to_err)   code = 3'd5;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state           <= IDLE;
         prev_order      <= '0;
         prev_pc         <= '0;
         prev_trap       <= 1'b0;
         idle_cnt        <= '0;
         retired_count_o <= '0;
         trap_count_o    <= '0;
         err_o           <= 1'b0;
         err_code_o      <= '0;
         err_order_o     <= '0;
      end else if (clear_i) begin
         state           <= IDLE;
         prev_order      <= '0;
         prev_pc         <= '0;
         prev_trap       <= 1'b0;
         idle_cnt        <= '0;
         retired_count_o <= '0;
         trap_count_o    <= '0;
         err_o           <= 1'b0;
         err_code_o      <= '0;
         err_order_o     <= '0;
      end else if (state != ERROR) begin
         if (rvfi_valid && active) begin
            if (!(&retired_count_o))
               retired_count_o <= retired_count_o + 1'b1;
            if (rvfi_trap && !(&trap_count_o))
               trap_count_o <= trap_count_o + 1'b1;
            prev_order <= rvfi_order;
            prev_pc    <= rvfi_pc_wdata;
            prev_trap  <= rvfi_trap;
         end
         if (state == RUN)
            idle_cnt <= rvfi_valid ? '0 : idle_cnt + 1'b1;
         if (code != 3'd0) begin
            state       <= ERROR;
            err_o       <= 1'b1;
            err_code_o  <= code;
            err_order_o <= rvfi_valid ? rvfi_order : 64'd0;
            idle_cnt    <= '0;
         end else if (rvfi_valid && active) begin
            state <= rvfi_halt ? HALTED : RUN;
         end
      end
   end

   assign state_o = state;

endmodule
